wb_uart_rx: RTL and testbench
=============================

Name: wb_uart_rx

Overview:
- Wishbone slave UART receiver; the receive-side counterpart of the transmit-only wb_uart.
- Samples the asynchronous rxd line and deframes 8N1 characters into a small FIFO.
- The CPU reads those characters through the cpuif Wishbone master.
- Sits on sys_clk beside wb_uart; the strobe is decoded by the top-level address split.

Parameters:
- CLK_FREQ, 50000000, sys_clk frequency in Hz.
- BAUD, 115200, line rate; DIV = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16.

Ports:
- clk  in  1  sys_clk
- rst  in  1  asynchronous reset, active-high
- rxd  in  1  serial input, asynchronous, idle high
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe, already address-decoded
- we_i  in  1  write enable
- adr_i  in  30  word address; only adr_i[0] decoded
- dat_i  in  32  write data
- dat_o  out  32  read data
- ack_o  out  1  acknowledge
- irq_o  out  1  level interrupt: FIFO non-empty

Behaviour:
- Reset state: ack_o=0, dat_o=0, irq_o=0, all flags 0, FIFO empty, FSM=IDLE, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame; the partial byte is never pushed.
- rxd passes through a 2-flop synchroniser (rxd_s); its 2 cycles of latency are accounted in tests.
- Baud counter cnt counts 0..DIV-1.
- FSM states and transitions:
  - IDLE: on rxd_s=0, go to START with cnt=0.
  - START: at cnt=DIV/2, if rxd_s=0 go to DATA with bit index 0 and cnt reset; if rxd_s=1 it is a glitch, return to IDLE.
  - DATA: sample rxd_s every DIV cycles into the shift register, LSB first; after bit 7, go to STOP.
  - STOP: sample after DIV cycles, then return to IDLE.
    - rxd_s=1: push the byte.
    - rxd_s=0: set frame_err, discard the byte, return to IDLE.
    - The FSM does not wait for rxd to return high; a held break re-enters START, fails the byte at STOP again and sets frame_err.
- Push while full: byte dropped, overrun set, FIFO unchanged.
- Push and pop in the same cycle: both take effect; count unchanged.
- FIFO: count is FIFO_AW+1 bits wide; pointers wrap modulo depth.
- Wishbone handshake:
  - ack_o asserts the cycle after cyc_i&stb_i&!ack_o, and is high for exactly 1 cycle.
  - Back-to-back accesses therefore take 2 cycles each.
  - dat_o is valid in the ack cycle and holds until the next access.
- Register adr_i[0]=0, DATA (read):
  - dat_o = {23'b0, valid, byte}, with valid=1 when the FIFO is non-empty.
  - Pops the FIFO in the ack cycle only when non-empty.
  - Read while empty returns 0x00000000 with no pop.
  - Writes are acked and ignored.
- Register adr_i[0]=1, STATUS (read):
  - bit0 nonempty, bit1 full, bit2 overrun, bit3 frame_err, bit4 parity_err.
  - bits[12:8] count; other bits 0.
- Register adr_i[0]=1, STATUS (write): W1C on bits 2..4.
  - Hardware set in the same cycle as a clear wins (flag stays 1).
- irq_o = nonempty, registered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled one DIV after bit 7; even parity.
  - On mismatch: set parity_err and discard the byte, but still check the stop bit before returning to IDLE.
- Undefined:
  - No PARITY state.
  - STATUS bit4 reads 0 and its W1C is ignored.

Decomposition:
- Shared package uart_pkg, also to be adopted by wb_uart:
  - register offsets REG_DATA/REG_STATUS;
  - status bit indices ST_NONEMPTY..ST_PARITY;
  - FSM state enum rx_state_t {IDLE, START, DATA, PARITY, STOP}.
- Sub-module sync_fifo (parameters WIDTH=8, AW):
  - ports push/pop/din/dout/full/empty/count;
  - first-word-fall-through, same async reset;
  - reusable later for a TX FIFO.

Test Plan:
- Tests use CLK_FREQ=1000000, BAUD=100000 (DIV=10).
- Send 0xA5 8N1 -> irq_o rises within 2 cycles of the stop-bit sample. STATUS reads 0x00000101. DATA reads 0x000001A5. Next DATA read returns 0x00000000 and irq_o=0.
- rxd low pulse of 3 cycles -> no byte pushed, STATUS=0, FSM back in IDLE.
- Send 0x3C with stop bit 0 -> frame_err set, count 0. Write STATUS 0x8 -> bit3 clears.
- Send 17 bytes 0x00..0x10 without reading -> full=1, count=16, overrun=1. Reads return 0x00..0x0F in order.
- Pop in the exact cycle a byte is pushed while count=3 -> count stays 3, data order preserved. Assert rst mid-DATA -> FIFO empty, all outputs 0, next clean byte 0x55 received correctly.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err set, byte discarded. Same byte with parity bit 1 -> accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Register map, status bit indices and receiver FSM states shared by
//           the Wishbone UART blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_PARITY    = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Value of the parity bit that makes the 9-bit group even.
  function automatic logic even_parity_bit(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO, depth 2**AW.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is refused even if a pop happens in the same cycle.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_uart_rx.sv
// ============================================================================
// Module  : wb_uart_rx
// Brief   : Wishbone slave UART receiver, 8N1 deframer feeding a 16-deep FIFO.
//           Optional even parity bit enabled by defining UART_RX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [29:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq_o
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rxd_meta_q, rxd_s_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             bit_tick;
  logic             rx_push, frame_set, byte_ok;

  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] fifo_count;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             rd_pop_q, rd_pop_d;
  logic             irq_q, irq_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_flag;
  logic             wb_req, wb_rd_data, wb_wr_status;
  logic [31:0]      status_word, data_word;
  logic             unused_bits;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_set;
  logic parity_err_q, parity_err_d;

  assign byte_ok     = ~par_bad_q;
  assign parity_flag = parity_err_q;
  assign unused_bits = ^{dat_i[31:5], dat_i[1:0], adr_i[29:1]};
`else
  assign byte_ok     = 1'b1;
  assign parity_flag = 1'b0;
  assign unused_bits = ^{dat_i[31:4], dat_i[1:0], adr_i[29:1]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  assign bit_tick = (cnt_q == CNT_LAST);

  // START checks mid-bit; every later sample lands DIV cycles after the last.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_push   = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          state_d = STOP;
          if (even_parity_bit(shift_q) != rxd_s_q) begin
            par_bad_d  = 1'b1;
            parity_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s_q) begin
            rx_push = byte_ok;
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (fifo_pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                                = '0;
    status_word[ST_NONEMPTY]                   = ~fifo_empty;
    status_word[ST_FULL]                       = fifo_full;
    status_word[ST_OVERRUN]                    = overrun_q;
    status_word[ST_FRAME_ERR]                  = frame_err_q;
    status_word[ST_PARITY]                     = parity_flag;
    status_word[ST_COUNT_LSB +: FIFO_AW + 1]   = fifo_count;
    data_word = fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_dout};
  end

  assign wb_req       = cyc_i & stb_i & ~ack_q;
  assign wb_rd_data   = wb_req & ~we_i & (adr_i[0] == REG_DATA);
  assign wb_wr_status = wb_req & we_i & (adr_i[0] == REG_STATUS);

  // Read data is captured at the request edge; the matching pop waits for the ack cycle.
  assign fifo_pop = ack_q & rd_pop_q;

  always_comb begin
    ack_d    = wb_req;
    rd_pop_d = wb_rd_data & ~fifo_empty;
    irq_d    = ~fifo_empty;
    dat_d    = dat_q;
    if (wb_req && !we_i) begin
      dat_d = (adr_i[0] == REG_DATA) ? data_word : status_word;
    end
    overrun_d   = (overrun_q & ~(wb_wr_status & dat_i[ST_OVERRUN])) |
                  (rx_push & fifo_full);
    frame_err_d = (frame_err_q & ~(wb_wr_status & dat_i[ST_FRAME_ERR])) | frame_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d = (parity_err_q & ~(wb_wr_status & dat_i[ST_PARITY])) | parity_set;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      rd_pop_q    <= 1'b0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      rd_pop_q    <= rd_pop_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq_o = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_uart_rx.sv
// ============================================================================
// Module  : tb_wb_uart_rx
// Brief   : Directed bench for wb_uart_rx with a queue-based receiver model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FIFO_AW  = 4;
  localparam int DEPTH    = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Read issued so that its pop lands on the same edge as the stop-bit push.
  localparam int PP_OFF = FRAME_BITS * DIV - 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        we_i = 1'b0;
  logic [29:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        irq_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_q[$];
  logic       m_overrun = 1'b0;
  logic       m_frame = 1'b0;
  logic       m_parity = 1'b0;

  logic        exp_ack = 1'b0;
  logic        exp_rd = 1'b0;
  logic [31:0] exp_dat = '0;

  wb_uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .cyc_i (cyc_i),
    .stb_i (stb_i),
    .we_i  (we_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .ack_o (ack_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int n;
    s = '0;
    n = m_q.size();
    s[0] = (n != 0);
    s[1] = (n == DEPTH);
    s[2] = m_overrun;
    s[3] = m_frame;
    s[4] = m_parity;
    s[12:8] = n[4:0];
    return s;
  endfunction

  // Bus checker: ack timing and read data against the model.
  always @(negedge clk) begin
    logic [7:0] b;
    if (rst) begin
      exp_ack = 1'b0;
      exp_rd  = 1'b0;
    end else begin
      if (exp_ack || ack_o) check("ack", 32'(ack_o), 32'(exp_ack));
      if (exp_ack && ack_o && exp_rd) check("rdata_model", dat_o, exp_dat);
      exp_rd = 1'b0;
      if (cyc_i && stb_i && !ack_o) begin
        exp_ack = 1'b1;
        if (!we_i) begin
          exp_rd = 1'b1;
          if (adr_i[0] == 1'b0) begin
            if (m_q.size() > 0) begin
              b = m_q.pop_front();
              exp_dat = {23'b0, 1'b1, b};
            end else begin
              exp_dat = '0;
            end
          end else begin
            exp_dat = model_status();
          end
        end else if (adr_i[0]) begin
          if (dat_i[2]) m_overrun = 1'b0;
          if (dat_i[3]) m_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
          if (dat_i[4]) m_parity = 1'b0;
`endif
        end
      end else begin
        exp_ack = 1'b0;
      end
    end
  end

  task automatic wait_ack(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack_o) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no ack expected ack within 8 cycles", name);
    end
  endtask

  task automatic wb_read(input logic a, output logic [31:0] d);
    @(posedge clk); #2;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = {29'b0, a};
    wait_ack("wb_read");
    d = dat_o;
    @(posedge clk); #2;
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic wb_write(input logic a, input logic [31:0] v);
    @(posedge clk); #2;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = {29'b0, a}; dat_i = v;
    wait_ack("wb_write");
    @(posedge clk); #2;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
  endtask

  task automatic read_expect(input logic a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    wb_read(a, d);
    check(name, d, exp);
  endtask

  // Drives one frame and then records its outcome in the model.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
    logic par;
    par = (^b) ^ bad_par;
    @(posedge clk); #2 rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #2 rxd = b[i];
    end
`ifdef UART_RX_PARITY_EN
    repeat (DIV) @(posedge clk);
    #2 rxd = par;
    if (bad_par) m_parity = 1'b1;
`else
    par = 1'b0;
`endif
    repeat (DIV) @(posedge clk);
    #2 rxd = stop_bit;
    repeat (DIV) @(posedge clk);
    #2 rxd = 1'b1;
    if (!stop_bit) begin
      m_frame = 1'b1;
`ifdef UART_RX_PARITY_EN
    end else if (!bad_par) begin
`else
    end else begin
`endif
      if (m_q.size() == DEPTH) m_overrun = 1'b1;
      else m_q.push_back(b);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_overrun = 1'b0;
    m_frame = 1'b0;
    m_parity = 1'b0;
  endtask

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected end of test");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_ack", 32'(ack_o), 32'h0);
    check("reset_dat", dat_o, 32'h0);
    check("reset_irq", 32'(irq_o), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    read_expect(1'b1, 32'h0000_0000, "reset_status");

    // Single character
    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    check("irq_after_A5", 32'(irq_o), 32'h1);
    read_expect(1'b1, 32'h0000_0101, "status_A5");
    read_expect(1'b0, 32'h0000_01A5, "data_A5");
    read_expect(1'b0, 32'h0000_0000, "data_empty");
    @(negedge clk);
    check("irq_after_drain", 32'(irq_o), 32'h0);

    // Short low glitch, then a normal character proves the FSM recovered
    @(posedge clk); #2 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #2 rxd = 1'b1;
    repeat (30) @(posedge clk);
    read_expect(1'b1, 32'h0000_0000, "status_glitch");
    send_frame(8'h5A, 1'b1, 1'b0);
    read_expect(1'b0, 32'h0000_015A, "data_after_glitch");

    // Bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    read_expect(1'b1, 32'h0000_0008, "status_frame_err");
    wb_write(1'b1, 32'h0000_0008);
    read_expect(1'b1, 32'h0000_0000, "status_frame_clr");

    // Overflow the FIFO
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    read_expect(1'b1, 32'h0000_1007, "status_full_overrun");
    for (int i = 0; i < 16; i++) read_expect(1'b0, 32'h0000_0100 | 32'(i), "data_flood");
    read_expect(1'b1, 32'h0000_0004, "status_overrun_only");
    wb_write(1'b1, 32'h0000_0004);
    read_expect(1'b1, 32'h0000_0000, "status_overrun_clr");

    // Pop on the same edge as a push with three entries queued
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    read_expect(1'b1, 32'h0000_0301, "status_count3");
    fork
      send_frame(8'h44, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (PP_OFF) @(posedge clk);
        wb_read(1'b0, d);
        check("data_pushpop", d, 32'h0000_0111);
      end
    join
    read_expect(1'b1, 32'h0000_0301, "status_pushpop");
    read_expect(1'b0, 32'h0000_0122, "data_order_1");
    read_expect(1'b0, 32'h0000_0133, "data_order_2");
    read_expect(1'b0, 32'h0000_0144, "data_order_3");

    // Reset in the middle of a frame with a byte already queued
    send_frame(8'h81, 1'b1, 1'b0);
    @(posedge clk); #2 rxd = 1'b0;
    repeat (40) @(posedge clk);
    #2 rst = 1'b1;
    rxd = 1'b1;
    model_reset();
    #1;
    check("midrst_ack", 32'(ack_o), 32'h0);
    check("midrst_dat", dat_o, 32'h0);
    check("midrst_irq", 32'(irq_o), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    read_expect(1'b1, 32'h0000_0000, "status_after_rst");
    send_frame(8'h55, 1'b1, 1'b0);
    read_expect(1'b0, 32'h0000_0155, "data_after_rst");
    read_expect(1'b1, 32'h0000_0000, "status_final");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    read_expect(1'b1, 32'h0000_0010, "status_parity_err");
    wb_write(1'b1, 32'h0000_0010);
    read_expect(1'b1, 32'h0000_0000, "status_parity_clr");
    send_frame(8'h07, 1'b1, 1'b0);
    read_expect(1'b0, 32'h0000_0107, "data_parity_ok");
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
